apb_slave_mem: RTL



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_slave_mem_if.sv | 26 ++
 rtl/apb_mem_array.sv | 30 +++
 rtl/apb_slave_mem.sv | 117 +++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, constants and address decode helper for the APB memory completer.
package apb_pkg;

   typedef enum logic {
      IDLE,
      ACCESS
   } apb_state_e;

   localparam int unsigned APB_ADDR_LSB   = 2;
   localparam int unsigned APB_WORD_BYTES = 4;

   // Error when the byte address is not word aligned or the word index falls past the array.
   function automatic logic apb_addr_err(input logic [31:0] addr, input int unsigned depth);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr % APB_WORD_BYTES) != 32'd0;
      out_of_range = (addr >> APB_ADDR_LSB) >= depth;
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 signal bundle with master (requester) and slave (completer) views.
interface apb_slave_mem_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  PSEL;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_mem_array.sv
// Word storage with asynchronous clear, one synchronous write port and one combinational read port.
module apb_mem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 64,
   parameter int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed memory, with fixed wait states and PSLVERR on bad addresses.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 64,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   apb_slave_mem_if.slave apb
);

   localparam int unsigned IdxW = $clog2(MEM_DEPTH);

   apb_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [31:0]           addr_ext;
   logic                  setup_err;
   logic [IdxW-1:0]       setup_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  mem_we;
   logic                  ready;

   always_comb begin
      addr_ext                 = '0;
      addr_ext[ADDR_WIDTH-1:0] = apb.PADDR;
   end

   assign setup_err = apb_addr_err(addr_ext, MEM_DEPTH);
   assign setup_idx = apb.PADDR[APB_ADDR_LSB +: IdxW];
   assign ready     = (state_q == ACCESS) && (cnt_q == 4'd0);

   apb_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IdxW)
   ) u_mem (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (apb.PWDATA),
      .raddr_i (setup_idx),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      write_d  = write_q;
      err_d    = err_q;
      prdata_d = prdata_q;
      mem_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            prdata_d = '0;
            // PENABLE high here is a protocol violation and is simply ignored.
            if (apb.PSEL && !apb.PENABLE) begin
               state_d  = ACCESS;
               cnt_d    = 4'(WAIT_CYCLES);
               idx_d    = setup_idx;
               write_d  = apb.PWRITE;
               err_d    = setup_err;
               prdata_d = (!apb.PWRITE && !setup_err) ? rd_data : '0;
            end
         end
         ACCESS: begin
            if (!apb.PSEL) begin
               // Master abort: drop the transfer without touching memory.
               state_d  = IDLE;
               prdata_d = '0;
            end else begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end
               if (apb.PENABLE && ready) begin
                  state_d  = IDLE;
                  prdata_d = '0;
                  mem_we   = write_q && !err_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         write_q  <= write_d;
         err_q    <= err_d;
         prdata_q <= prdata_d;
      end
   end

   assign apb.PREADY  = ready;
   assign apb.PSLVERR = ready && err_q;
   assign apb.PRDATA  = prdata_q;

endmodule
